router_ctrl: RTL and testbench
==============================

ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 30, consecutive unserviced cycles before a port soft reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 pkt_valid  input  1  packet byte valid from source.
REQ-005 data_in  input  2  header address bits; 0..2 select a port, 3 is invalid.
REQ-006 fifo_full  input  3  per-port output FIFO full.
REQ-007 fifo_empty  input  3  per-port output FIFO empty.
REQ-008 read_enb  input  3  per-port read enable from destination.
REQ-009 parity_done, low_pkt_valid  input  1 each  status from the register block.
REQ-010 detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  output  1 each  state decodes driving the register block.
REQ-011 write_enb_reg  output  1  register block may write a byte this cycle.
REQ-012 busy  output  1  source must hold the current byte.
REQ-013 write_enb  output  3  one-hot FIFO write enable.
REQ-014 fifo_full_sel  output  1  fifo_full bit of the latched port.
REQ-015 vld_out  output  3  per-port data available.
REQ-016 soft_reset  output  3  per-port one-cycle FIFO flush pulse, registered.

Function
REQ-017 The FSM shall have states DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, one transition per clk.
REQ-018 DECODE_ADDRESS: pkt_valid and data_in<3 and fifo_empty[data_in] -> LOAD_FIRST_DATA; pkt_valid and data_in<3 and not empty -> WAIT_TILL_EMPTY; otherwise, including data_in==3, stay (header dropped).
REQ-019 addr_reg shall load data_in only on a DECODE_ADDRESS exit; it holds otherwise.
REQ-020 WAIT_TILL_EMPTY -> LOAD_FIRST_DATA when fifo_empty[addr_reg], else stay.
REQ-021 LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-022 LOAD_DATA: fifo_full_sel -> FIFO_FULL_STATE (priority); else !pkt_valid -> LOAD_PARITY; else stay.
REQ-023 FIFO_FULL_STATE -> LOAD_AFTER_FULL when !fifo_full_sel, else stay.
REQ-024 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
REQ-025 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-026 CHECK_PARITY_ERROR: fifo_full_sel -> FIFO_FULL_STATE; else DECODE_ADDRESS.
REQ-027 soft_reset[addr_reg]=1 in any state other than DECODE_ADDRESS shall force DECODE_ADDRESS next cycle, overriding REQ-020..026.
REQ-028 Decodes, combinational from state only: detect_add=DECODE_ADDRESS, lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA, laf_state=LOAD_AFTER_FULL, full_state=FIFO_FULL_STATE, rst_int_reg=CHECK_PARITY_ERROR.
REQ-029 write_enb_reg = LOAD_DATA | LOAD_AFTER_FULL | LOAD_PARITY.
REQ-030 busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-031 write_enb = one-hot(addr_reg) when write_enb_reg, else 3'b000; never more than one bit set.
REQ-032 fifo_full_sel = fifo_full[addr_reg]; vld_out[i] = ~fifo_empty[i], combinational.
REQ-033 Per port i, a counter wide enough for TIMEOUT shall increment each cycle vld_out[i] & ~read_enb[i], and clear when read_enb[i] or ~vld_out[i].
REQ-034 When counter i reaches TIMEOUT-1 while still incrementing, soft_reset[i] shall be 1 the next cycle for exactly one cycle and counter i shall clear.
REQ-035 Ports' counters are independent; simultaneous timeouts pulse simultaneously.

Reset
REQ-036 rst=1 shall immediately force state=DECODE_ADDRESS, addr_reg=0, all counters=0, soft_reset=3'b000, without waiting for clk.
REQ-037 During and after reset: detect_add=1, all other decodes 0, busy=0, write_enb=3'b000.
REQ-038 rst asserted mid-packet shall abandon the packet; the first post-reset edge evaluates DECODE_ADDRESS.

Verification
REQ-039 Header data_in=1, fifo_empty=3'b111, 4 payload bytes, pkt_valid low -> states DECODE, LFD, LD x4, LP, CPE, DECODE; write_enb=3'b010 during LD/LP.
REQ-040 data_in=2, fifo_empty[2]=0 for 5 cycles -> WAIT_TILL_EMPTY, busy=1 5 cycles, then LFD.
REQ-041 fifo_full[0]=1 during LD on port 0 -> FIFO_FULL_STATE, write_enb=0, busy=1; release with low_pkt_valid=1, parity_done=0 -> LAF then LP.
REQ-042 vld_out[1]=1, read_enb[1]=0 for TIMEOUT=30 cycles -> soft_reset[1]=1 one cycle; FSM on port 1 returns to DECODE next cycle.
REQ-043 Header data_in=3 with pkt_valid=1 -> remains DECODE_ADDRESS, addr_reg unchanged, write_enb=0.
REQ-044 rst pulse mid-LOAD_DATA (no clk edge) -> detect_add=1, write_enb=0 immediately.

Source files
------------

// File: rtl/router_ctrl.sv
// router_ctrl: packet router FSM steering bytes into one of three output FIFOs,
// with per-port timeout soft reset of FIFOs the destination fails to drain.
module router_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy,
  output logic [2:0] write_enb,
  output logic       fifo_full_sel,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {
    DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA,
    FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR
  } state_t;
  state_t state, next;
  logic [1:0] addr_reg;
  logic [3:0] empty_x, full_x, sr_x;
  logic [2:0] stall;
  logic [CW-1:0] cnt [3];
  // Pad to four entries so address 3 indexes a defined (zero) bit
  assign empty_x = {1'b0, fifo_empty};
  assign full_x = {1'b0, fifo_full};
  assign sr_x = {1'b0, soft_reset};
  assign fifo_full_sel = full_x[addr_reg];
  assign vld_out = ~fifo_empty;
  assign stall = vld_out & ~read_enb;
  always_comb begin
    next = state;
    case (state)
      DECODE_ADDRESS:     if (pkt_valid && data_in != 2'd3) next = empty_x[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:    if (empty_x[addr_reg]) next = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:    next = LOAD_DATA;
      LOAD_DATA:          next = fifo_full_sel ? FIFO_FULL_STATE : (!pkt_valid ? LOAD_PARITY : LOAD_DATA);
      FIFO_FULL_STATE:    if (!fifo_full_sel) next = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    next = parity_done ? DECODE_ADDRESS : (low_pkt_valid ? LOAD_PARITY : LOAD_DATA);
      LOAD_PARITY:        next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: next = fifo_full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
    endcase
    if (state != DECODE_ADDRESS && sr_x[addr_reg]) next = DECODE_ADDRESS;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= DECODE_ADDRESS;
      addr_reg <= 2'd0;
    end else begin
      state <= next;
      if (state == DECODE_ADDRESS && next != DECODE_ADDRESS) addr_reg <= data_in;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      soft_reset <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        soft_reset[i] <= stall[i] && cnt[i] == CW'(TIMEOUT - 1);
        cnt[i] <= (stall[i] && cnt[i] != CW'(TIMEOUT - 1)) ? cnt[i] + CW'(1) : '0;
      end
    end
  assign detect_add = state == DECODE_ADDRESS;
  assign lfd_state = state == LOAD_FIRST_DATA;
  assign ld_state = state == LOAD_DATA;
  assign laf_state = state == LOAD_AFTER_FULL;
  assign full_state = state == FIFO_FULL_STATE;
  assign rst_int_reg = state == CHECK_PARITY_ERROR;
  assign write_enb_reg = ld_state || laf_state || state == LOAD_PARITY;
  assign busy = !(detect_add || ld_state);
  assign write_enb = write_enb_reg ? 3'b001 << addr_reg : 3'b000;
endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: directed stimulus with a behavioural reference model compared every cycle.
module tb_router_ctrl;
  localparam int TIMEOUT = 30;
  localparam int DA = 0, WTE = 1, LFD = 2, LD = 3, FFS = 4, LAF = 5, LP = 6, CPE = 7;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pkt_valid = 1'b0, parity_done = 1'b0, low_pkt_valid = 1'b0;
  logic [1:0] data_in = 2'd0;
  logic [2:0] fifo_full = 3'b000, fifo_empty = 3'b111, read_enb = 3'b000;
  logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic write_enb_reg, busy, fifo_full_sel;
  logic [2:0] write_enb, vld_out, soft_reset;
  int n_chk = 0;
  int n_fail = 0;

  router_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy), .write_enb(write_enb),
    .fifo_full_sel(fifo_full_sel), .vld_out(vld_out), .soft_reset(soft_reset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of the packet, latched port, idle-cycle counts per port
  int ph = DA;
  logic [1:0] ma = 2'd0;
  int idle [3] = '{0, 0, 0};
  logic [2:0] msr = 3'b000;
  logic [3:0] emp4, full4;
  assign emp4 = {1'b0, fifo_empty};
  assign full4 = {1'b0, fifo_full};

  always @(posedge clk or posedge rst) begin
    int nxt;
    if (rst) begin
      ph = DA;
      ma = 2'd0;
      idle = '{0, 0, 0};
      msr = 3'b000;
    end else begin
      nxt = ph;
      if (ph == DA) begin
        if (pkt_valid && data_in != 2'd3) begin
          nxt = emp4[data_in] ? LFD : WTE;
          ma = data_in;
        end
      end else if (ph == WTE) nxt = emp4[ma] ? LFD : WTE;
      else if (ph == LFD) nxt = LD;
      else if (ph == LD) nxt = full4[ma] ? FFS : (pkt_valid ? LD : LP);
      else if (ph == FFS) nxt = full4[ma] ? FFS : LAF;
      else if (ph == LAF) nxt = parity_done ? DA : (low_pkt_valid ? LP : LD);
      else if (ph == LP) nxt = CPE;
      else nxt = full4[ma] ? FFS : DA;
      if (ph != DA && msr[ma]) nxt = DA;
      ph = nxt;
      for (int p = 0; p < 3; p++) begin
        msr[p] = 1'b0;
        if (!fifo_empty[p] && !read_enb[p]) begin
          idle[p] = idle[p] + 1;
          if (idle[p] == TIMEOUT) begin
            idle[p] = 0;
            msr[p] = 1'b1;
          end
        end else idle[p] = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic wr;
    wr = ph == LD || ph == LAF || ph == LP;
    chk("decodes", {10'd0, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg},
        {10'd0, ph == DA, ph == LFD, ph == LD, ph == LAF, ph == FFS, ph == CPE});
    chk("write_enb", {12'd0, write_enb_reg, write_enb}, {12'd0, wr, wr ? 3'b001 << ma : 3'b000});
    chk("busy_full_vld", {11'd0, busy, fifo_full_sel, vld_out},
        {11'd0, !(ph == DA || ph == LD), full4[ma], ~fifo_empty});
    chk("soft_reset", {13'd0, soft_reset}, {13'd0, msr});
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    tick(2);
    chk("reset_state", {13'd0, detect_add, busy, 1'b0}, 16'h0004);
    chk("reset_we", {13'd0, write_enb}, 16'h0000);
    rst = 1'b0;
    // port 1 packet, four payload cycles
    pkt_valid = 1'b1; data_in = 2'd1;
    tick();
    chk("p1_lfd", {15'd0, lfd_state}, 16'h0001);
    data_in = 2'd0;
    tick(4);
    chk("p1_ld_we", {12'd0, ld_state, write_enb}, 16'h000a);
    pkt_valid = 1'b0;
    tick();
    chk("p1_lp_we", {13'd0, write_enb}, 16'h0002);
    tick();
    chk("p1_cpe", {15'd0, rst_int_reg}, 16'h0001);
    tick();
    chk("p1_done", {15'd0, detect_add}, 16'h0001);
    // port 2 not empty: wait five cycles
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
    tick();
    pkt_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("p2_wait_busy", {15'd0, busy}, 16'h0001);
    fifo_empty = 3'b111;
    tick();
    chk("p2_lfd", {15'd0, lfd_state}, 16'h0001);
    tick(4);
    chk("p2_back", {15'd0, detect_add}, 16'h0001);
    // port 0 FIFO full during load
    pkt_valid = 1'b1; data_in = 2'd0;
    tick(2);
    fifo_full = 3'b001;
    tick();
    chk("p0_full", {11'd0, full_state, busy, write_enb}, 16'h0018);
    tick();
    fifo_full = 3'b000; low_pkt_valid = 1'b1;
    tick();
    chk("p0_laf", {12'd0, laf_state, write_enb}, 16'h0009);
    pkt_valid = 1'b0;
    tick();
    chk("p0_lp", {15'd0, write_enb_reg}, 16'h0001);
    low_pkt_valid = 1'b0;
    tick(2);
    // parity_done exit from LOAD_AFTER_FULL
    pkt_valid = 1'b1; data_in = 2'd2;
    tick(2);
    fifo_full = 3'b100;
    tick();
    fifo_full = 3'b000; parity_done = 1'b1;
    tick(2);
    chk("pd_exit", {15'd0, detect_add}, 16'h0001);
    parity_done = 1'b0; pkt_valid = 1'b0;
    tick();
    // timeout on port 1 while waiting on port 1
    pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b101;
    tick();
    pkt_valid = 1'b0;
    tick(28);
    chk("to_before", {13'd0, soft_reset}, 16'h0000);
    tick();
    chk("to_pulse", {12'd0, busy, soft_reset}, 16'h000a);
    fifo_empty = 3'b111;
    tick();
    chk("to_after", {12'd0, detect_add, soft_reset}, 16'h0008);
    // invalid header keeps address 1
    pkt_valid = 1'b1; data_in = 2'd3; fifo_full = 3'b010;
    tick();
    chk("hdr3", {11'd0, detect_add, fifo_full_sel, write_enb}, 16'h0018);
    pkt_valid = 1'b0; fifo_full = 3'b000;
    tick();
    // simultaneous timeouts, port 0 serviced once
    fifo_empty = 3'b000;
    tick(9);
    read_enb = 3'b001;
    tick();
    read_enb = 3'b000;
    tick(20);
    chk("multi_to", {13'd0, soft_reset}, 16'h0006);
    tick(10);
    chk("port0_to", {13'd0, soft_reset}, 16'h0001);
    fifo_empty = 3'b111;
    tick();
    // async reset mid LOAD_DATA
    pkt_valid = 1'b1; data_in = 2'd2;
    tick(2);
    chk("pre_rst_ld", {12'd0, ld_state, write_enb}, 16'h000c);
    rst = 1'b1;
    #1;
    chk("async_rst", {12'd0, detect_add, write_enb}, 16'h0008);
    tick();
    rst = 1'b0; pkt_valid = 1'b0;
    tick();
    pkt_valid = 1'b1; data_in = 2'd0;
    tick();
    chk("post_rst_lfd", {15'd0, lfd_state}, 16'h0001);
    pkt_valid = 1'b0;
    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
